float_result_display_mux: RTL
=============================

Name: float_result_display_mux

Overview:
Downstream consumer of the floating-point adder FSM. Captures the 32-bit IEEE-754 sum when the adder strobes valid, then time-multiplexes it as hex onto a 4-digit, common-anode 7-segment display. A switch selects the upper or lower 16-bit half of the result. Inf/NaN results blink the display.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (ghost suppression)
BLINK_FRAMES, 32, full 4-digit scan frames per blink phase

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
result  in  32  IEEE-754 single-precision sum from the adder
result_valid  in  1  one-cycle strobe; capture result
page_sel  in  1  raw switch: 0 = low half [15:0], 1 = high half [31:16]
seg  out  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a
an  out  4  active-low digit enables, an[0] = rightmost
dp  out  1  active-low decimal point

Behaviour:
- Reset values (async, immediate): held=0, sync flops=0, refresh_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=0; an=4'b1111, seg=7'b1000000, dp=1.
- Hold register: on a clk edge with result_valid=1, held<=result. result_valid=0 keeps the current value. A capture is visible on outputs 2 cycles later (hold reg + output reg).
- page_sel passes through a 2-flop synchronizer. The effective page changes 2 cycles after the input, and outputs follow 1 cycle after that.
- Refresh counter counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, digit_idx advances D0->D1->D2->D3->D0.
- Frame counter increments on the D3->D0 transition. When it reaches BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
- Special value: special=1 when held[30:23]==8'hFF (Inf or NaN). Zero, denormal and finite values are never special.
- Output register, updated every cycle from the current state:
  - an = all ones if refresh_cnt < BLANK_CYCLES, or if special && blink_phase. Otherwise an = ~(4'b0001 << digit_idx).
  - seg = hex decode of held[16*page + 4*digit_idx +: 4], using the standard 0-F active-low patterns (b and d lowercase).
  - dp = 0 only when digit_idx==3, page==1 and the digit is enabled. It marks the high half.
- Simultaneous events: result_valid on the same edge as a digit change is allowed. The new value appears with the normal 2-cycle latency, and only a whole value is ever shown (no nibble mixing). Toggling page_sel mid-slot switches the nibble at the next output update.
- reset asserted mid-scan blanks the display immediately. After release, scanning restarts at D0 with a blank period.
- No handshake back to the adder: the block is always ready, and a strobe is never lost.

Test Plan:
Simulation parameters: REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset while digit_idx=2 mid-slot -> an=1111, seg=1000000, dp=1 with no clock edge. After release, the first digit enabled is an=1110, after 1 blank cycle.
- Strobe 0x40490FDB with page_sel=0 -> digit slots show D0 B(0000011), D1 D(0100001), D2 F(0001110), D3 0(1000000). dp=1 throughout.
- Set page_sel=1 -> after 3 cycles, digits show D0 9(0010000), D1 4(0011001), D2 0(1000000), D3 4(0011001). dp=0 only while an=0111.
- Slot timing -> an repeats 1111,1110,1110,1110, 1111,1101x3, 1111,1011x3, 1111,0111x3. The period is 16 cycles.
- Strobe 0x7FC00000 (NaN) -> an stays 1111 for 2 frames, scans for 2 frames, and alternates. Strobe 0x7F7FFFFF -> no blinking.
- Strobe on the cycle refresh_cnt wraps 3->0, then hold result_valid=0 for 40 cycles -> the new value is shown consistently from 2 cycles later, and the value persists.

Source files
------------

// File: rtl/float_result_display_mux.sv
// float_result_display_mux: latches the adder's IEEE-754 sum and scans one 16-bit half of it
// as hex across a 4-digit common-anode 7-segment display, blinking the display on Inf/NaN.
module float_result_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic        result_valid,
  input  logic        page_sel,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] BLANK_LIMIT  = RW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(BLINK_FRAMES - 1);

  // Active-low g..a patterns; b and d are the lowercase glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [31:0]   held_r;
  logic          page_meta_r;
  logic          page_r;
  logic [RW-1:0] refresh_cnt_r;
  logic [1:0]    digit_idx_r;
  logic [FW-1:0] frame_cnt_r;
  logic          blink_phase_r;

  logic          refresh_wrap_s;
  logic          special_s;
  logic          blank_s;
  logic [3:0]    nibble_s;
  logic [3:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;

  // Whole-word capture so a digit change never shows a mix of old and new nibbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_r <= 32'h0000_0000;
    end else if (result_valid) begin
      held_r <= result;
    end
  end

  // Two-flop synchronizer for the raw page switch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_meta_r <= 1'b0;
      page_r      <= 1'b0;
    end else begin
      page_meta_r <= page_sel;
      page_r      <= page_meta_r;
    end
  end

  // Slot timer, digit scan and blink cadence; a frame ends on the D3->D0 step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (refresh_wrap_s) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= digit_idx_r + 2'd1;
      if (digit_idx_r == 2'd3) begin
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FW'(1);
        end
      end
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1);
    end
  end

  // Next display image from the current scan position, page and held value.
  always_comb begin
    refresh_wrap_s = (refresh_cnt_r == REFRESH_LAST);
    special_s      = (held_r[30:23] == 8'hFF);
    blank_s        = (refresh_cnt_r < BLANK_LIMIT) || (special_s && blink_phase_r);
    nibble_s       = held_r[{page_r, digit_idx_r, 2'b00} +: 4];
    seg_nxt_s      = hex_to_seg(nibble_s);
    an_nxt_s       = 4'b1111;
    dp_nxt_s       = 1'b1;
    if (blank_s) begin
      an_nxt_s = 4'b1111;
      dp_nxt_s = 1'b1;
    end else begin
      an_nxt_s = ~(4'b0001 << digit_idx_r);
      dp_nxt_s = ~((digit_idx_r == 2'd3) && page_r);
    end
  end

  // Registered pins; reset blanks the display without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1000000;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt_s;
      seg <= seg_nxt_s;
      dp  <= dp_nxt_s;
    end
  end

endmodule
